// File: rtl/delay_seq_pkg.sv
// Shared types and widths for the delay chain sequencer and its arg-max helper.
package delay_seq_pkg;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int CW  = DW + 1;
  localparam int IW  = 2;
  localparam int PCW = 8;

  typedef enum logic [1:0] {IDLE, SEARCH, RUN, DONE} state_t;
endpackage

// File: rtl/delay_argmax.sv
// Sequential strict-greater arg-max over the latched channel delays, one channel per cycle.
module delay_argmax
  import delay_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go,
  input  logic [NCH-1:0][DW-1:0] delays,
  input  logic [NCH-1:0]         mask,
  output logic                   done,
  output logic [IW-1:0]          idx,
  output logic [DW-1:0]          val
);

  logic          active;
  logic [IW-1:0] step;
  logic [IW-1:0] sel;
  logic [DW-1:0] cand;

  always_comb begin
    sel  = go ? '0 : step;
    cand = mask[sel] ? delays[sel] : '0;
  end

  // go restarts the search from channel 0, so a stale search is simply discarded
  always_ff @(posedge clk) begin
    if (!reset) begin
      active <= 1'b0;
      step   <= '0;
      done   <= 1'b0;
      idx    <= '0;
      val    <= '0;
    end else begin
      done <= 1'b0;
      if (go) begin
        val    <= cand;
        idx    <= '0;
        step   <= IW'(1);
        active <= 1'b1;
      end else if (active) begin
        if (cand > val) begin
          val <= cand;
          idx <= step;
        end
        if (step == IW'(NCH - 1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
        step <= step + IW'(1);
      end
    end
  end

endmodule

// File: rtl/delay_chain_sequencer.sv
// Latches four channel delays, finds the longest enabled one, then fires a
// fixed-width pulse on each enabled channel as a shared counter reaches its delay.
module delay_chain_sequencer
  import delay_seq_pkg::*;
#(
  parameter int PULSE_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  input  logic [DW-1:0]  DATA0,
  input  logic [DW-1:0]  DATA1,
  input  logic [DW-1:0]  DATA2,
  input  logic [DW-1:0]  DATA3,
  input  logic [NCH-1:0] en_mask,
  output logic           busy,
  output logic           done,
  output logic [NCH-1:0] ch_out,
  output logic [IW-1:0]  max_idx,
  output logic [DW-1:0]  max_val
);

  state_t                 state;
  logic [NCH-1:0][DW-1:0] lat_d;
  logic [NCH-1:0]         lat_mask;
  logic                   go_q;
  logic [CW-1:0]          run_cnt;
  logic [CW-1:0]          run_next;
  logic [CW-1:0]          run_last;
  logic [NCH-1:0][PCW-1:0] pcnt;
  logic [NCH-1:0][PCW-1:0] pcnt_nxt;
  logic [NCH-1:0]         ch_nxt;
  logic [NCH-1:0]         fire;
  logic                   am_done;
  logic [IW-1:0]          am_idx;
  logic [DW-1:0]          am_val;

  delay_argmax u_argmax (
    .clk    (clk),
    .reset  (reset),
    .go     (go_q),
    .delays (lat_d),
    .mask   (lat_mask),
    .done   (am_done),
    .idx    (am_idx),
    .val    (am_val)
  );

  // Counter value for the next RUN cycle; entering RUN from SEARCH starts at 0
  always_comb begin
    run_next = (state == RUN) ? run_cnt + CW'(1) : '0;
    run_last = CW'(max_val) + CW'(PULSE_W - 1);
    fire     = '0;
    pcnt_nxt = '0;
    ch_nxt   = '0;
    for (int i = 0; i < NCH; i++) begin
      fire[i] = lat_mask[i] && (CW'(lat_d[i]) == run_next);
      if (fire[i]) begin
        pcnt_nxt[i] = PCW'(PULSE_W - 1);
        ch_nxt[i]   = 1'b1;
      end else if (pcnt[i] != '0) begin
        pcnt_nxt[i] = pcnt[i] - PCW'(1);
        ch_nxt[i]   = 1'b1;
      end
    end
  end

  // go_q masks the arg-max done flag from any search that an abort cut short
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ch_out   <= '0;
      max_idx  <= '0;
      max_val  <= '0;
      lat_d    <= '0;
      lat_mask <= '0;
      go_q     <= 1'b0;
      run_cnt  <= '0;
      pcnt     <= '0;
    end else begin
      go_q <= 1'b0;
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state  <= IDLE;
        busy   <= 1'b0;
        ch_out <= '0;
        pcnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              lat_d    <= {DATA3, DATA2, DATA1, DATA0};
              lat_mask <= en_mask;
              busy     <= 1'b1;
              go_q     <= 1'b1;
              state    <= SEARCH;
            end
          end
          SEARCH: begin
            if (am_done && !go_q) begin
              max_idx <= am_idx;
              max_val <= am_val;
              run_cnt <= '0;
              if (lat_mask == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state  <= RUN;
                ch_out <= ch_nxt;
                pcnt   <= pcnt_nxt;
              end
            end
          end
          RUN: begin
            if (run_cnt == run_last) begin
              state  <= DONE;
              done   <= 1'b1;
              ch_out <= '0;
              pcnt   <= '0;
            end else begin
              run_cnt <= run_next;
              ch_out  <= ch_nxt;
              pcnt    <= pcnt_nxt;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_delay_chain_sequencer.sv
// Randomized and directed checks of delay_chain_sequencer against a cycle-indexed model.
module tb_delay_chain_sequencer;
  localparam int PW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] DATA0, DATA1, DATA2, DATA3;
  logic [3:0]  en_mask;
  logic        busy;
  logic        done;
  logic [3:0]  ch_out;
  logic [1:0]  max_idx;
  logic [15:0] max_val;

  int          total = 0;
  int          bad = 0;
  logic [1:0]  old_idx = '0;
  logic [15:0] old_val = '0;

  delay_chain_sequencer #(.PULSE_W(PW)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .DATA0   (DATA0),
    .DATA1   (DATA1),
    .DATA2   (DATA2),
    .DATA3   (DATA3),
    .en_mask (en_mask),
    .busy    (busy),
    .done    (done),
    .ch_out  (ch_out),
    .max_idx (max_idx),
    .max_val (max_val)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0][15:0] pack4(input int a, input int b, input int c, input int e);
    logic [3:0][15:0] r;
    r[0] = 16'(a);
    r[1] = 16'(b);
    r[2] = 16'(c);
    r[3] = 16'(e);
    return r;
  endfunction

  // Runs one sequence; n counts periods after the start-sampling edge
  task automatic run_sequence(input string tag, input logic [3:0][15:0] d, input logic [3:0] mask,
                              input int kill_at, input bit kill_reset, input bit disturb, input bit hammer);
    int          exp_val, exp_idx, dn, last;
    logic [3:0]  exp_ch;
    logic [1:0]  want_idx;
    logic [15:0] want_val;
    bit          killed, exp_busy, exp_done;
    exp_val = 0;
    exp_idx = 0;
    for (int i = 0; i < 4; i++)
      if (mask[i] && int'(d[i]) > exp_val) begin
        exp_val = int'(d[i]);
        exp_idx = i;
      end
    dn = (mask == 4'b0000) ? 5 : 5 + exp_val + PW;
    last = (kill_at >= 0) ? kill_at + 3 : dn + 2;
    @(negedge clk);
    DATA0 = d[0]; DATA1 = d[1]; DATA2 = d[2]; DATA3 = d[3];
    en_mask = mask;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= last; n++) begin
      @(posedge clk); #1;
      killed = (kill_at >= 0) && (n > kill_at);
      if (killed) begin
        exp_ch = '0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (kill_reset) begin
          want_idx = '0;
          want_val = '0;
        end else if (kill_at >= 5) begin
          want_idx = 2'(exp_idx);
          want_val = 16'(exp_val);
        end else begin
          want_idx = old_idx;
          want_val = old_val;
        end
      end else begin
        for (int i = 0; i < 4; i++)
          exp_ch[i] = mask[i] && (n >= 5 + int'(d[i])) && (n < 5 + int'(d[i]) + PW);
        exp_busy = (n <= dn);
        exp_done = (n == dn);
        want_idx = (n >= 5) ? 2'(exp_idx) : old_idx;
        want_val = (n >= 5) ? 16'(exp_val) : old_val;
      end
      total += 5;
      if (ch_out !== exp_ch) begin
        bad++;
        $display("[TB] FAIL %s ch_out n=%0d got=%b exp=%b", tag, n, ch_out, exp_ch);
      end
      if (busy !== exp_busy) begin
        bad++;
        $display("[TB] FAIL %s busy n=%0d got=%b exp=%b", tag, n, busy, exp_busy);
      end
      if (done !== exp_done) begin
        bad++;
        $display("[TB] FAIL %s done n=%0d got=%b exp=%b", tag, n, done, exp_done);
      end
      if (max_idx !== want_idx) begin
        bad++;
        $display("[TB] FAIL %s max_idx n=%0d got=%0d exp=%0d", tag, n, max_idx, want_idx);
      end
      if (max_val !== want_val) begin
        bad++;
        $display("[TB] FAIL %s max_val n=%0d got=%0d exp=%0d", tag, n, max_val, want_val);
      end
      if (n == kill_at) begin
        if (kill_reset) reset = 1'b0;
        else abort = 1'b1;
      end
      if (n == kill_at + 1) begin
        reset = 1'b1;
        abort = 1'b0;
      end
      if (disturb && n == 7) begin
        DATA0 = 16'($urandom); DATA1 = 16'($urandom);
        DATA2 = 16'($urandom); DATA3 = 16'($urandom);
        en_mask = 4'($urandom);
        start = 1'b1;
      end
      if (disturb && n == 8) start = 1'b0;
      if (hammer && n == dn - 1) start = 1'b1;
      if (hammer && n == dn + 1) start = 1'b0;
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b1;
    if (kill_at >= 0 && kill_reset) begin
      old_idx = '0;
      old_val = '0;
    end else if (!(kill_at >= 0 && kill_at < 5)) begin
      old_idx = 2'(exp_idx);
      old_val = 16'(exp_val);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    DATA0 = 16'd3; DATA1 = 16'd4; DATA2 = 16'd5; DATA3 = 16'd6;
    en_mask = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total += 3;
      if (busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset busy/done got=%b%b exp=00", busy, done);
      end
      if (ch_out !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL reset ch_out got=%b exp=0000", ch_out);
      end
      if (max_idx !== 2'd0 || max_val !== 16'd0) begin
        bad++;
        $display("[TB] FAIL reset max got=%0d/%0d exp=0/0", max_idx, max_val);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_plan_cases();
    run_sequence("plan1", pack4(10, 40, 25, 5), 4'hF, -1, 1'b0, 1'b0, 1'b0);
    run_sequence("plan_ties", pack4(20, 20, 7, 20), 4'hF, -1, 1'b0, 1'b0, 1'b0);
    run_sequence("plan_mask", pack4(100, 3, 100, 9), 4'b1010, -1, 1'b0, 1'b0, 1'b0);
    run_sequence("plan_nomask", pack4(30, 12, 8, 1), 4'b0000, -1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_latch_and_ignore();
    run_sequence("zero_delays", pack4(0, 0, 0, 0), 4'hF, -1, 1'b0, 1'b1, 1'b0);
    run_sequence("disturb", pack4(12, 2, 9, 14), 4'b1101, -1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    run_sequence("abort20", pack4(10, 40, 25, 5), 4'hF, 20, 1'b0, 1'b0, 1'b0);
    run_sequence("abort_search", pack4(60, 2, 3, 4), 4'hF, 3, 1'b0, 1'b0, 1'b0);
    run_sequence("after_abort", pack4(1, 2, 3, 4), 4'hF, -1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midrun();
    run_sequence("reset20", pack4(10, 40, 25, 5), 4'hF, 20, 1'b1, 1'b0, 1'b0);
    run_sequence("after_reset", pack4(7, 7, 2, 0), 4'b0111, -1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_sequence("b2b_a", pack4(6, 11, 3, 11), 4'hF, -1, 1'b0, 1'b0, 1'b1);
    run_sequence("b2b_b", pack4(0, 5, 0, 2), 4'b1001, -1, 1'b0, 1'b0, 1'b1);
    run_sequence("long", pack4(1000, 999, 1000, 0), 4'hF, -1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0][15:0] d;
    int shared;
    for (int t = 0; t < 25; t++) begin
      shared = $urandom_range(0, 40);
      for (int i = 0; i < 4; i++)
        d[i] = ($urandom_range(0, 3) == 0) ? 16'(shared) : 16'($urandom_range(0, 80));
      run_sequence("random", d, 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : -1,
                   1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
    DATA0 = '0; DATA1 = '0; DATA2 = '0; DATA3 = '0;
    en_mask = '0;
    test_reset();
    test_plan_cases();
    test_latch_and_ignore();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
